rle_byte_packer: RTL and testbench

RLE_BYTE_PACKER -- requirements
Module: rle_byte_packer

---
 rtl/rle_byte_packer.sv | 163 ++++++++++++++++
 tb/tb_rle_byte_packer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rle_byte_packer.sv
// Pixel-to-byte packer: raw pixels or RLE records (count byte + pixel bytes MSB first); LINE_MARKER_EN adds a 0x00 after each RLE line.
// Latency: first output byte is valid the cycle after the pixel that closes a record (raw: after every pixel).
// Backpressure: o_ready drops while bytes are emitted; o_byte/o_valid hold steady while i_ready is low.
module rle_byte_packer #(
    parameter int PIXEL_WIDTH = 16,
    parameter int FRAME_WIDTH = 640,
    parameter int MAX_RUN     = 255
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [PIXEL_WIDTH-1:0] i_pixel,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_mode,
    output logic [7:0]             o_byte,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_line_done
);

    localparam int          NB      = PIXEL_WIDTH / 8;
    localparam logic [1:0]  LAST_B  = 2'(NB - 1);
    localparam int          CW      = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(FRAME_WIDTH - 1);
    localparam logic [7:0]  MAX_CNT = 8'(MAX_RUN);
`ifdef LINE_MARKER_EN
    localparam bit          MARKER  = 1'b1;
`else
    localparam bit          MARKER  = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACCUM     = 3'd1,
        EMIT_CNT  = 3'd2,
        EMIT_PIX  = 3'd3,
        EMIT_MARK = 3'd4
    } state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          col, col_n;
    logic                   line_mode, line_mode_n;
    logic [PIXEL_WIDTH-1:0] run_pix, run_pix_n;   // also the byte shifter for the pixel being emitted
    logic [7:0]             run_cnt, run_cnt_n;
    logic                   pend_vld, pend_vld_n;
    logic [PIXEL_WIDTH-1:0] pend_pix, pend_pix_n;
    logic                   eol, eol_n;
    logic [1:0]             bidx, bidx_n;
    logic                   done_n;
    logic                   cur_mode;
    logic                   last_col;

    // State and datapath registers; reset drops any held run or partial line.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            col         <= '0;
            line_mode   <= 1'b0;
            run_pix     <= '0;
            run_cnt     <= 8'd0;
            pend_vld    <= 1'b0;
            pend_pix    <= '0;
            eol         <= 1'b0;
            bidx        <= 2'd0;
            o_line_done <= 1'b0;
        end else begin
            state       <= state_n;
            col         <= col_n;
            line_mode   <= line_mode_n;
            run_pix     <= run_pix_n;
            run_cnt     <= run_cnt_n;
            pend_vld    <= pend_vld_n;
            pend_pix    <= pend_pix_n;
            eol         <= eol_n;
            bidx        <= bidx_n;
            o_line_done <= done_n;
        end
    end

    // Next-state, run accumulation and byte output selection.
    always_comb begin
        state_n     = state;
        col_n       = col;
        line_mode_n = line_mode;
        run_pix_n   = run_pix;
        run_cnt_n   = run_cnt;
        pend_vld_n  = pend_vld;
        pend_pix_n  = pend_pix;
        eol_n       = eol;
        bidx_n      = bidx;
        done_n      = 1'b0;
        cur_mode    = (col == '0) ? i_mode : line_mode;
        last_col    = (col == LAST_COL);

        o_ready = (state == IDLE) || (state == ACCUM);
        o_valid = (state == EMIT_CNT) || (state == EMIT_PIX) || (state == EMIT_MARK);
        case (state)
            EMIT_CNT: o_byte = run_cnt;
            EMIT_PIX: o_byte = run_pix[PIXEL_WIDTH-1 -: 8];
            default:  o_byte = 8'h00;
        endcase

        // Pixel intake: the mode is only taken from i_mode at column 0.
        if (o_ready && i_valid) begin
            line_mode_n = cur_mode;
            col_n       = last_col ? '0 : col + CW'(1);
            eol_n       = last_col;
            if (!cur_mode) begin
                run_pix_n = i_pixel;
                bidx_n    = 2'd0;
                state_n   = EMIT_PIX;
            end else if (state == IDLE) begin
                run_pix_n = i_pixel;
                run_cnt_n = 8'd1;
                state_n   = last_col ? EMIT_CNT : ACCUM;
            end else if ((i_pixel == run_pix) && (run_cnt < MAX_CNT)) begin
                run_cnt_n = run_cnt + 8'd1;
                state_n   = last_col ? EMIT_CNT : ACCUM;
            end else begin
                pend_vld_n = 1'b1;
                pend_pix_n = i_pixel;
                state_n    = EMIT_CNT;
            end
        end

        // Byte emission: advance only when the byte is taken downstream.
        if (o_valid && i_ready) begin
            case (state)
                EMIT_CNT: begin
                    bidx_n  = 2'd0;
                    state_n = EMIT_PIX;
                end
                EMIT_PIX: begin
                    run_pix_n = run_pix << 8;
                    bidx_n    = bidx + 2'd1;
                    if (bidx == LAST_B) begin
                        if (line_mode && pend_vld) begin
                            run_pix_n  = pend_pix;
                            run_cnt_n  = 8'd1;
                            pend_vld_n = 1'b0;
                            state_n    = eol ? EMIT_CNT : ACCUM;
                        end else if (eol && line_mode && MARKER) begin
                            state_n = EMIT_MARK;
                        end else if (eol) begin
                            eol_n   = 1'b0;
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                EMIT_MARK: begin
                    eol_n   = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rle_byte_packer.sv
// Directed bench for rle_byte_packer: two instances (MAX_RUN=3 and 255), FRAME_WIDTH=8, PIXEL_WIDTH=16.
// Latency: each line vector is driven and its byte stream and line-done pulse collected cycle by cycle.
// Backpressure: vectors run with i_ready high, a fixed 5-cycle stall, or pseudo-random i_ready.
module tb_rle_byte_packer;

`ifdef LINE_MARKER_EN
    localparam bit MARK = 1'b1;
`else
    localparam bit MARK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] pixel;
    logic        mode;
    logic        vld;
    logic        rdy;
    logic        sel;

    logic [7:0]  ob0, ob1;
    logic        ov0, ov1, ordy0, ordy1, od0, od1;
    logic [7:0]  q_byte;
    logic        q_valid, q_ready, q_done;

    int checks = 0;
    int errors = 0;

    rle_byte_packer #(.PIXEL_WIDTH(16), .FRAME_WIDTH(8), .MAX_RUN(3)) u_dut3 (
        .CLK(clk), .RST(rst), .i_pixel(pixel), .i_valid(vld & ~sel), .o_ready(ordy0),
        .i_mode(mode), .o_byte(ob0), .o_valid(ov0), .i_ready(sel ? 1'b1 : rdy),
        .o_line_done(od0)
    );

    rle_byte_packer #(.PIXEL_WIDTH(16), .FRAME_WIDTH(8), .MAX_RUN(255)) u_dut255 (
        .CLK(clk), .RST(rst), .i_pixel(pixel), .i_valid(vld & sel), .o_ready(ordy1),
        .i_mode(mode), .o_byte(ob1), .o_valid(ov1), .i_ready(sel ? rdy : 1'b1),
        .o_line_done(od1)
    );

    assign q_byte  = sel ? ob1 : ob0;
    assign q_valid = sel ? ov1 : ov0;
    assign q_ready = sel ? ordy1 : ordy0;
    assign q_done  = sel ? od1 : od0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         sel;    // 0: MAX_RUN=3 instance, 1: MAX_RUN=255 instance
        logic [7:0]   modes;  // bit i = i_mode driven with pixel i
        logic [1:0]   bp;     // 0: ready, 1: 5-cycle stall on first byte, 2: random
        logic [127:0] pix;    // pixel 0 in the top 16 bits
        logic [191:0] exp;    // expected bytes, right-aligned, first byte most significant
        logic [7:0]   nexp;   // expected byte count excluding any line marker
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int pi, nb, ndone, last_x, done_c, stall_left, tail, n;
        logic [7:0] eb;
        n = int'(v.nexp) + ((MARK && v.modes[0]) ? 1 : 0);
        pi = 0; nb = 0; ndone = 0; last_x = -1; done_c = -2; tail = 0;
        stall_left = (v.bp == 2'd1) ? 5 : 0;
        sel = v.sel;
        for (int cyc = 0; cyc < 400 && tail < 3; cyc++) begin
            @(negedge clk);
            if (q_done) begin
                ndone++;
                done_c = cyc;
            end
            if (ndone > 0) tail++;
            if (pi < 8) begin
                vld   = 1'b1;
                pixel = v.pix[(7 - pi) * 16 +: 16];
                mode  = v.modes[pi];
            end else begin
                vld = 1'b0;
            end
            if (v.bp == 2'd1 && q_valid && nb == 0 && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
                chk($sformatf("v%0d_stall_byte", id), 32'(q_byte), 32'(v.exp[(int'(v.nexp) - 1) * 8 +: 8]));
                chk($sformatf("v%0d_stall_ready", id), 32'(q_ready), 32'd0);
            end else if (v.bp == 2'd2) begin
                rdy = 1'($urandom_range(0, 1));
            end else begin
                rdy = 1'b1;
            end
            if (q_ready && vld) pi++;
            if (q_valid && rdy) begin
                if (nb < n) begin
                    eb = (nb < int'(v.nexp)) ? v.exp[(int'(v.nexp) - 1 - nb) * 8 +: 8] : 8'h00;
                    chk($sformatf("v%0d_byte%0d", id, nb), 32'(q_byte), 32'(eb));
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL v%0d_extra_byte: got %0h beyond %0d expected bytes", id, q_byte, n);
                end
                nb++;
                last_x = cyc;
            end
        end
        vld = 1'b0;
        rdy = 1'b1;
        chk($sformatf("v%0d_pixels_taken", id), 32'(pi), 32'd8);
        chk($sformatf("v%0d_byte_count", id), 32'(nb), 32'(n));
        chk($sformatf("v%0d_done_pulses", id), 32'(ndone), 32'd1);
        chk($sformatf("v%0d_done_timing", id), 32'(done_c), 32'(last_x + 1));
    endtask

    initial begin
        rst = 1'b1; vld = 1'b0; rdy = 1'b1; sel = 1'b0; pixel = 16'h0; mode = 1'b0;

        vecs[0] = '{sel: 1'b0, modes: 8'hFF, bp: 2'd0, pix: {8{16'hABCD}},
                    exp: 192'({8'h03, 16'hABCD, 8'h03, 16'hABCD, 8'h02, 16'hABCD}), nexp: 8'd9};
        vecs[1] = '{sel: 1'b0, modes: 8'h00, bp: 2'd0,
                    pix: {16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C, 16'h0D0E, 16'h0F10},
                    exp: 192'({16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C, 16'h0D0E, 16'h0F10}),
                    nexp: 8'd16};
        vecs[2] = '{sel: 1'b1, modes: 8'hFF, bp: 2'd0, pix: {{7{16'h1111}}, 16'h2222},
                    exp: 192'({8'h07, 16'h1111, 8'h01, 16'h2222}), nexp: 8'd6};
        vecs[3] = '{sel: 1'b1, modes: 8'hFF, bp: 2'd2, pix: {4{16'h1111, 16'h2222}},
                    exp: {4{8'h01, 16'h1111, 8'h01, 16'h2222}}, nexp: 8'd24};
        vecs[4] = '{sel: 1'b0, modes: 8'hFF, bp: 2'd0,
                    pix: {16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0002, 16'h0002, 16'h0003, 16'h0003},
                    exp: 192'({8'h03, 16'h0001, 8'h01, 16'h0001, 8'h02, 16'h0002, 8'h02, 16'h0003}),
                    nexp: 8'd12};
        vecs[5] = '{sel: 1'b1, modes: 8'h01, bp: 2'd0, pix: {16'hAAAA, {7{16'h5A5A}}},
                    exp: 192'({8'h01, 16'hAAAA, 8'h07, 16'h5A5A}), nexp: 8'd6};
        vecs[6] = '{sel: 1'b0, modes: 8'hFE, bp: 2'd0, pix: {8{16'h7777}},
                    exp: 192'({8{16'h7777}}), nexp: 8'd16};
        vecs[7] = '{sel: 1'b0, modes: 8'hFF, bp: 2'd1, pix: {8{16'hABCD}},
                    exp: 192'({8'h03, 16'hABCD, 8'h03, 16'hABCD, 8'h02, 16'hABCD}), nexp: 8'd9};
        vecs[8] = '{sel: 1'b1, modes: 8'hFF, bp: 2'd0, pix: {8{16'h5555}},
                    exp: 192'({8'h08, 16'h5555}), nexp: 8'd3};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid3", 32'(ov0), 32'd0);
        chk("rst_ready3", 32'(ordy0), 32'd1);
        chk("rst_byte3", 32'(ob0), 32'd0);
        chk("rst_done3", 32'(od0), 32'd0);
        chk("rst_valid255", 32'(ov1), 32'd0);
        chk("rst_ready255", 32'(ordy1), 32'd1);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset while a raw pixel is being emitted, then a fresh RLE line.
        sel = 1'b1; mode = 1'b0; pixel = 16'h1234; vld = 1'b1; rdy = 1'b0;
        @(negedge clk);
        vld = 1'b0;
        chk("pre_rst_valid", 32'(q_valid), 32'd1);
        chk("pre_rst_byte", 32'(q_byte), 32'h12);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(q_valid), 32'd0);
        chk("mid_rst_byte", 32'(q_byte), 32'd0);
        chk("mid_rst_done", 32'(q_done), 32'd0);
        rst = 1'b0; rdy = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(q_ready), 32'd1);
        run_vec(8, vecs[8]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
